// File: rtl/uart_receiver_if.sv
// Receiver-side bundle: line and enable in, received byte and status strobes out.
interface uart_receiver_if;
   logic       en;
   logic       in;
   logic [7:0] data_out;
   logic       valid;
   logic       busy;
   logic       frame_err;

   modport master (
      output en, in,
      input  data_out, valid, busy, frame_err
   );

   modport slave (
      input  en, in,
      output data_out, valid, busy, frame_err
   );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receive stage: two-flop synchroniser, mid-bit sampling, one-cycle
// valid / frame_err strobes.
module uart_receiver #(
   parameter int CLKS_PER_BIT = 16
) (
   input logic             clk,
   input logic             rst,
   uart_receiver_if.slave  rx_if
);
   localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
   localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
   } state_t;

   state_t      state_q;
   logic        sync1_q;
   logic        sync2_q;
   logic [15:0] cnt_q;
   logic [2:0]  idx_q;
   logic [7:0]  shift_q;
   logic [7:0]  data_out_q;
   logic        valid_q;
   logic        busy_q;
   logic        frame_err_q;

   wire rx_s = sync2_q;

   always_ff @(posedge clk) begin
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      if (rst || !rx_if.en) begin
         // Disable behaves like reset but keeps the last good byte visible.
         if (rst) begin
            data_out_q <= 8'h00;
         end
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         state_q <= IDLE;
         cnt_q   <= 16'd0;
         idx_q   <= 3'd0;
         shift_q <= 8'h00;
         busy_q  <= 1'b0;
      end else begin
         sync1_q <= rx_if.in;
         sync2_q <= sync1_q;
         case (state_q)
            IDLE: begin
               if (!rx_s) begin
                  state_q <= START;
                  busy_q  <= 1'b1;
                  cnt_q   <= 16'd0;
               end
            end
            START: begin
               if (cnt_q == HALF_LAST) begin
                  if (!rx_s) begin
                     state_q <= DATA;
                     cnt_q   <= 16'd0;
                     idx_q   <= 3'd0;
                  end else begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            DATA: begin
               if (cnt_q == BIT_LAST) begin
                  shift_q <= {rx_s, shift_q[7:1]};
                  cnt_q   <= 16'd0;
                  if (idx_q == 3'd7) begin
                     state_q <= STOP;
                  end else begin
                     idx_q <= idx_q + 3'd1;
                  end
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            STOP: begin
               // Leaving at mid-stop-bit lets a following start bit be caught with no gap.
               if (cnt_q == BIT_LAST) begin
                  cnt_q <= 16'd0;
                  if (rx_s) begin
                     data_out_q <= shift_q;
                     valid_q    <= 1'b1;
                     state_q    <= IDLE;
                     busy_q     <= 1'b0;
                  end else begin
                     frame_err_q <= 1'b1;
                     state_q     <= WAIT_HIGH;
                  end
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            WAIT_HIGH: begin
               if (rx_s) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign rx_if.data_out  = data_out_q;
   assign rx_if.valid     = valid_q;
   assign rx_if.busy      = busy_q;
   assign rx_if.frame_err = frame_err_q;
endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: frame table plus glitch/abort sequences,
// strobes matched against a scoreboard of expected byte, kind and cycle.
module tb_uart_receiver;
   localparam int CPB = 16;
   localparam int H   = CPB / 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   uart_receiver_if rx_if ();

   uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
      .clk   (clk),
      .rst   (rst),
      .rx_if (rx_if.slave)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit         is_err;
      logic [7:0] data;
      int         at;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   typedef struct {
      logic [7:0] data;
      bit         stop_b;
      int         gap;
      bit         exp_valid;
      logic [7:0] exp_dout;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Strobe monitor: every valid/frame_err must match the head of the scoreboard.
   always @(negedge clk) begin
      if (rx_if.valid || rx_if.frame_err) begin
         check("strobe_exclusive", 32'(rx_if.valid & rx_if.frame_err), 32'd0);
         if (sb.size() == 0) begin
            check("unexpected_strobe", {30'd0, rx_if.valid, rx_if.frame_err}, 32'd0);
         end else begin
            mon_e = sb.pop_front();
            check("strobe_kind", 32'(rx_if.frame_err), 32'(mon_e.is_err));
            check("strobe_cycle", cyc, mon_e.at);
            check("data_out", 32'(rx_if.data_out), 32'(mon_e.data));
            $display("strobe at cycle %0d: valid=%0b frame_err=%0b data_out=0x%02h",
                     cyc, rx_if.valid, rx_if.frame_err, rx_if.data_out);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Called at posedge+1; the first low bit is captured on the next edge (k).
   task automatic send_frame(input logic [7:0] d, input bit stop_b, input logic [7:0] exp_dout);
      logic [9:0] bits;
      int         k;
      bits = {stop_b, d, 1'b0};
      k    = cyc + 1;
      sb.push_back('{is_err: !stop_b, data: exp_dout, at: k + 2 + H + 9 * CPB});
      for (int i = 0; i < 10; i++) begin
         rx_if.in = bits[i];
         step(CPB);
      end
   endtask

   // Sends start and bits 0..3 of d, then aborts midway through bit 4.
   task automatic abort_frame(input logic [7:0] d, input bit use_rst);
      logic [9:0] bits;
      bits = {1'b1, d, 1'b0};
      for (int i = 0; i < 5; i++) begin
         rx_if.in = bits[i];
         step(CPB);
      end
      rx_if.in = bits[5];
      step(H);
      if (use_rst) rst = 1'b1;
      else rx_if.en = 1'b0;
      rx_if.in = 1'b1;
      step(1);
      rst      = 1'b0;
      rx_if.en = 1'b1;
      check(use_rst ? "rst_abort_busy" : "en_abort_busy", 32'(rx_if.busy), 32'd0);
      check(use_rst ? "rst_abort_valid" : "en_abort_valid", 32'(rx_if.valid), 32'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      vecs[0] = '{8'hA5, 1'b1, 20, 1'b1, 8'hA5};
      vecs[1] = '{8'h3C, 1'b0,  0, 1'b0, 8'hA5};
      vecs[2] = '{8'h5A, 1'b1, 20, 1'b1, 8'h5A};
      vecs[3] = '{8'h00, 1'b1,  0, 1'b1, 8'h00};
      vecs[4] = '{8'hFF, 1'b1, 20, 1'b1, 8'hFF};
      vecs[5] = '{8'h01, 1'b1,  5, 1'b1, 8'h01};
      vecs[6] = '{8'h80, 1'b1, 20, 1'b1, 8'h80};

      rx_if.en = 1'b1;
      rx_if.in = 1'b1;
      rst      = 1'b1;
      step(3);
      rst = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         check("reset_idle", {21'd0, rx_if.data_out, rx_if.valid, rx_if.busy, rx_if.frame_err}, 32'd0);
      end
      @(posedge clk);
      #1;

      // Short low pulse: START entered, start sample sees high, back to IDLE.
      k = cyc + 1;
      rx_if.in = 1'b0;
      step(3);
      rx_if.in = 1'b1;
      check("glitch_busy_rise", 32'(rx_if.busy), 32'd1);
      step(7);
      check("glitch_busy_hold", 32'(rx_if.busy), 32'd1);
      step(1);
      check("glitch_busy_fall", 32'(rx_if.busy), 32'd0);
      check("glitch_cycle", cyc, k + 2 + H);
      check("glitch_data_out", 32'(rx_if.data_out), 32'd0);
      $display("glitch pulse: busy cleared at cycle %0d", cyc);
      step(20);

      for (int i = 0; i < 7; i++) begin
         $display("frame %0d: data=0x%02h stop=%0b expect_valid=%0b expect_data_out=0x%02h",
                  i, vecs[i].data, vecs[i].stop_b, vecs[i].exp_valid, vecs[i].exp_dout);
         send_frame(vecs[i].data, vecs[i].stop_b, vecs[i].exp_dout);
         if (!vecs[i].stop_b) begin
            step(40);
            check("wait_high_busy", 32'(rx_if.busy), 32'd1);
            check("wait_high_data_out", 32'(rx_if.data_out), 32'(vecs[i].exp_dout));
            rx_if.in = 1'b1;
            step(4);
            check("wait_high_release", 32'(rx_if.busy), 32'd0);
            step(10);
         end
         step(vecs[i].gap);
      end

      $display("abort by en during bit 4 of 0x81");
      abort_frame(8'h81, 1'b0);
      step(40);
      check("en_abort_data_out", 32'(rx_if.data_out), 32'h80);
      send_frame(8'h81, 1'b1, 8'h81);
      step(20);

      $display("abort by rst during bit 4 of 0x81");
      abort_frame(8'h81, 1'b1);
      check("rst_abort_data_out", 32'(rx_if.data_out), 32'h00);
      step(40);
      send_frame(8'h81, 1'b1, 8'h81);
      step(20);

      check("scoreboard_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
